// File: rtl/ball_state_tx_if.sv
// Sample handshake bundle between the game server and the ball-state transmitter.
// Master offers an (x, y) sample; slave raises send_ready when it can take one.
interface ball_state_tx_if;
   logic        send_valid;
   logic        send_ready;
   logic [10:0] ball_x;
   logic [10:0] ball_y;

   modport master (output send_valid, output ball_x, output ball_y, input send_ready);
   modport slave  (input send_valid, input ball_x, input ball_y, output send_ready);
endinterface

// File: rtl/ball_state_tx.sv
// Serializes one (x, y) ball sample as a 6-byte UART frame: sync, x hi/lo, y hi/lo, checksum.
// Optional even-parity bit per byte when BALL_TX_PARITY_EN is defined.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_IDLE   | line high, send_ready=1, waiting for a sample
// S_START  | driving the start bit (0) of the current byte
// S_DATA   | driving data bit bit_idx of the current byte, LSB first
// S_PARITY | driving the even-parity bit (parity builds only)
// S_STOP   | driving the stop bit (1); advances byte or ends frame
module ball_state_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic                 clock,
   input  logic                 reset,
   ball_state_tx_if.slave       s_if,
   output logic                 tx_serial,
   output logic                 busy,
   output logic [7:0]           frames_sent
);

   localparam int unsigned     CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           state_q, state_d;
   logic [2:0]       byte_idx_q, byte_idx_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [10:0]      x_q, x_d;
   logic [10:0]      y_q, y_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       frames_q, frames_d;
   logic             tx_q, tx_d;

   logic [7:0]       cur_byte;
   logic [7:0]       csum_new;
   logic [2:0]       bit_nxt;
   logic             bit_done;

   assign s_if.send_ready = (state_q == S_IDLE);
   assign busy            = (state_q != S_IDLE);
   assign tx_serial       = tx_q;
   assign frames_sent     = frames_q;

   assign bit_done = (cnt_q == '0);
   assign bit_nxt  = bit_idx_q + 3'd1;
   assign csum_new = {5'b0, s_if.ball_x[10:8]} + s_if.ball_x[7:0]
                   + {5'b0, s_if.ball_y[10:8]} + s_if.ball_y[7:0];

   always_comb begin
      cur_byte = csum_q;
      case (byte_idx_q)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = {5'b0, x_q[10:8]};
         3'd2:    cur_byte = x_q[7:0];
         3'd3:    cur_byte = {5'b0, y_q[10:8]};
         3'd4:    cur_byte = y_q[7:0];
         default: cur_byte = csum_q;
      endcase
   end

   // tx_d is computed from the next state so the line changes on the same edge as the state.
   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      cnt_d      = cnt_q;
      x_d        = x_q;
      y_d        = y_q;
      csum_d     = csum_q;
      frames_d   = frames_q;
      tx_d       = tx_q;

      if (state_q != S_IDLE) begin
         cnt_d = bit_done ? CNT_RELOAD : cnt_q - CNT_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (s_if.send_valid) begin
               x_d        = s_if.ball_x;
               y_d        = s_if.ball_y;
               csum_d     = csum_new;
               byte_idx_d = 3'd0;
               bit_idx_d  = 3'd0;
               cnt_d      = CNT_RELOAD;
               tx_d       = 1'b0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_done) begin
               bit_idx_d = 3'd0;
               tx_d      = cur_byte[0];
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               if (bit_idx_q == 3'd7) begin
`ifdef BALL_TX_PARITY_EN
                  tx_d    = ^cur_byte;
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_idx_d = bit_nxt;
                  tx_d      = cur_byte[bit_nxt];
               end
            end
         end
         S_PARITY: begin
            if (bit_done) begin
               tx_d    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               if (byte_idx_q == 3'd5) begin
                  frames_d = frames_q + 8'd1;
                  tx_d     = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  tx_d       = 1'b0;
                  state_d    = S_START;
               end
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         byte_idx_q <= 3'd0;
         bit_idx_q  <= 3'd0;
         cnt_q      <= '0;
         x_q        <= 11'd0;
         y_q        <= 11'd0;
         csum_q     <= 8'd0;
         frames_q   <= 8'd0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         cnt_q      <= cnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         csum_q     <= csum_d;
         frames_q   <= frames_d;
         tx_q       <= tx_d;
      end
   end

endmodule

// File: tb/tb_ball_state_tx.sv
// Scoreboard bench for ball_state_tx: a cycle-level reference tracks acceptance and frame timing,
// a line decoder reassembles frames from tx_serial and compares them with queued expectations.
module tb_ball_state_tx;
   localparam int CPB = 4;
   localparam int H   = CPB / 2;
`ifdef BALL_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME_CYC = 6 * NB * CPB;
   localparam int WAIT_LIM  = FRAME_CYC * 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx;
   logic       busy;
   logic [7:0] frames_sent;

   ball_state_tx_if bus ();

   ball_state_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
      .clock       (clk),
      .reset       (rst),
      .s_if        (bus),
      .tx_serial   (tx),
      .busy        (busy),
      .frames_sent (frames_sent)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [47:0] sb[$];
   int exp_cnt    = 0;
   int exp_frames = 0;
   int exp_total  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] exp_frame(input int x, input int y);
      int b1 = x / 256;
      int b2 = x % 256;
      int b3 = y / 256;
      int b4 = y % 256;
      int b5 = (b1 + b2 + b3 + b4) % 256;
      return {8'hA5, 8'(b1), 8'(b2), 8'(b3), 8'(b4), 8'(b5)};
   endfunction

   // Reference: an idle transmitter accepts a valid sample, then stays busy one frame length.
   initial begin : ref_model
      forever begin
         @(posedge clk);
         if (rst) begin
            exp_cnt    = 0;
            exp_frames = 0;
            exp_total  = 0;
            sb.delete();
         end else if (exp_cnt == 0) begin
            if (bus.send_valid === 1'b1) begin
               sb.push_back(exp_frame(int'(bus.ball_x), int'(bus.ball_y)));
               exp_cnt = FRAME_CYC;
            end
         end else begin
            exp_cnt--;
            if (exp_cnt == 0) begin
               exp_frames = (exp_frames + 1) % 256;
               exp_total++;
            end
         end
      end
   end

   initial begin : cycle_checker
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("ready_busy_frames", {54'd0, bus.send_ready, busy, frames_sent},
                {54'd0, exp_cnt == 0, exp_cnt != 0, 8'(exp_frames)});
            if (exp_cnt == 0) chk("idle_line", 64'(tx), 64'd1);
         end
      end
   end

   initial begin : line_decoder
      bit         act = 1'b0;
      int         dcnt = 0;
      logic [7:0] sh = 8'd0;
      logic       pbit = 1'b0;
      logic [7:0] fr[$];
      logic [47:0] got;
      logic [47:0] exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            act = 1'b0;
            fr.delete();
         end else begin
            if (!act) begin
               if (tx === 1'b0) begin
                  act  = 1'b1;
                  dcnt = 0;
               end
            end else begin
               dcnt++;
            end
            if (act) begin
               if (dcnt == H) chk("start_bit", 64'(tx), 64'd0);
               for (int k = 0; k < 8; k++) if (dcnt == (k + 1) * CPB + H) sh[k] = tx;
               if (dcnt == 9 * CPB + H) pbit = tx;
               if (dcnt == (NB - 1) * CPB + H) begin
                  chk("stop_bit", 64'(tx), 64'd1);
`ifdef BALL_TX_PARITY_EN
                  chk("parity_bit", 64'(pbit), 64'(^sh));
`endif
                  fr.push_back(sh);
                  act = 1'b0;
                  if (fr.size() == 6) begin
                     got = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
                     if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got %0h expected none", got);
                     end else begin
                        exp = sb.pop_front();
                        chk("frame_bytes", 64'(got), 64'(exp));
                     end
                     fr.delete();
                  end
               end
            end
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < WAIT_LIM; i++) begin
         if (bus.send_ready === 1'b1) return;
         @(posedge clk);
         #1;
      end
      checks++;
      failures++;
      $display("FAIL wait_ready: got timeout expected send_ready=1 within %0d cycles", WAIT_LIM);
   endtask

   task automatic send(input logic [10:0] xv, input logic [10:0] yv);
      wait_ready();
      bus.ball_x     = xv;
      bus.ball_y     = yv;
      bus.send_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.send_valid = 1'b0;
      bus.ball_x     = 11'($urandom);
      bus.ball_y     = 11'($urandom);
   endtask

   initial begin : watchdog
      #(150000 * 10);
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.send_valid = 1'b0;
      bus.ball_x     = 11'd0;
      bus.ball_y     = 11'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {61'd0, tx, bus.send_ready, busy}, {61'd0, 3'b110});
      chk("reset_frames", 64'(frames_sent), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Abandon a frame partway through byte 3.
      send(11'($urandom), 11'($urandom));
      repeat (3 * NB * CPB + 5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_line", {61'd0, tx, bus.send_ready, busy}, {61'd0, 3'b110});
      chk("midreset_frames", 64'(frames_sent), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      send(11'd500, 11'd300);
      wait_ready();
      chk("nominal_frames", 64'(frames_sent), 64'd1);

      // Back-to-back: valid held high across the ready edge.
      wait_ready();
      bus.ball_x     = 11'd0;
      bus.ball_y     = 11'd2047;
      bus.send_valid = 1'b1;
      @(posedge clk);
      #1;
      wait_ready();
      @(posedge clk);
      #1;
      chk("b2b_restart", {62'd0, tx, bus.send_ready}, {62'd0, 2'b00});
      bus.send_valid = 1'b0;

      send(11'($urandom), 11'($urandom));
      repeat (50) @(posedge clk);
      #1;
      bus.ball_x     = 11'($urandom);
      bus.send_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("isolation_ready", 64'(bus.send_ready), 64'd0);
      bus.send_valid = 1'b0;

      for (int i = 0; i < 8; i++) begin
         wait_ready();
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         send(11'($urandom), 11'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 100)) @(posedge clk);
            #1 bus.send_valid = 1'b1;
            @(posedge clk);
            #1 bus.send_valid = 1'b0;
         end
      end

      for (int i = 0; i < 300; i++) begin
         if (exp_total >= 256) break;
         send(11'($urandom), 11'($urandom));
      end
      wait_ready();
      repeat (2) @(posedge clk);
      #1;
      chk("frames_wrap", 64'(frames_sent), 64'(8'(exp_total)));
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
